// File: rtl/handshake_rr_arbiter.sv
// Round-robin merge of NUM_REQ ready/valid requesters into one registered output slot.
// The slot refills in the same cycle it drains, so a steady stream moves one payload per clock.
module handshake_rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int WIDTH   = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     CLK,
  input  logic                     ASYNCRESET,
  input  logic [NUM_REQ-1:0]       in_valid,
  output logic [NUM_REQ-1:0]       in_ready,
  input  logic [NUM_REQ*WIDTH-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [IDX_W-1:0]         out_src,
  output logic                     out_orr,
  output logic                     out_andr
);

  logic                          full;
  logic [IDX_W-1:0]              ptr;
  logic [IDX_W-1:0]              sel;
  logic [IDX_W-1:0]              ptr_nxt;
  logic                          has_sel;
  logic                          found;
  logic                          can_load;
  logic                          accept;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_data;
  logic [WIDTH-1:0]              sel_data;
  logic [WIDTH-1:0]              data_q;
  logic [IDX_W-1:0]              src_q;
  logic                          orr_q;
  logic                          andr_q;

  assign req_data = in_data;
  assign has_sel  = |in_valid;
  assign can_load = !full || out_ready;
  assign accept   = can_load && has_sel && !ASYNCRESET;

  // Rotating search: the first valid requester at or after ptr wins.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && in_valid[(int'(ptr) + k) % NUM_REQ]) begin
        sel   = IDX_W'((int'(ptr) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
  end

  assign sel_data = req_data[sel];
  assign ptr_nxt  = (int'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;

  // Reset is folded in so no requester sees a grant while the block is held in reset.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rdy
    assign in_ready[i] = accept && (int'(sel) == i);
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      full   <= 1'b0;
      ptr    <= '0;
      data_q <= '0;
      src_q  <= '0;
      orr_q  <= 1'b0;
      andr_q <= 1'b0;
    end else if (accept) begin
      full   <= 1'b1;
      ptr    <= ptr_nxt;
      data_q <= sel_data;
      src_q  <= sel;
      orr_q  <= |sel_data;
      andr_q <= &sel_data;
    end else if (full && out_ready) begin
      full <= 1'b0;
    end
  end

  assign out_valid = full;
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign out_orr   = orr_q;
  assign out_andr  = andr_q;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Directed bench for handshake_rr_arbiter: reset, streaming, wrap, backpressure,
// asynchronous reset and fairness, each against hand-computed expectations.
module tb_handshake_rr_arbiter;

  logic        CLK = 1'b0;
  logic        ASYNCRESET;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [11:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_src;
  logic        out_orr;
  logic        out_andr;

  int nvec = 0;
  int nmis = 0;

  handshake_rr_arbiter #(.NUM_REQ(3), .WIDTH(4), .IDX_W(2)) dut (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .out_orr(out_orr), .out_andr(out_andr)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    assert ($onehot0(in_ready)) else $error("in_ready not one-hot: %b", in_ready);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [3:0] d);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".src"},   32'(out_src),   32'(s));
    chk({tag, ".data"},  32'(out_data),  32'(d));
  endtask

  logic [2:0] pat     [6] = '{3'b011, 3'b110, 3'b111, 3'b010, 3'b111, 3'b011};
  logic [1:0] exp_src [6] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
  logic [1:0] seq_src [6] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
  int gap;

  initial begin
    // reset held with every requester asking
    ASYNCRESET = 1'b1;
    in_valid   = 3'b111;
    in_data    = {4'h3, 4'h2, 4'h1};
    out_ready  = 1'b0;
    tick();
    tick();
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd0);
    chk("rst.out_data",  32'(out_data),  32'd0);
    @(negedge CLK);
    ASYNCRESET = 1'b0;
    #1;
    chk("rel.in_ready", 32'(in_ready), 32'b001);
    tick();
    chk_out("first", 1'b1, 2'd0, 4'h1);
    chk("first.bp_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("first.next_ready", 32'(in_ready), 32'b010);

    // streaming at one transfer per cycle
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out($sformatf("stream%0d", i), 1'b1, seq_src[i], 4'(seq_src[i]) + 4'h1);
    end

    // lone req2 with all-ones payload, then pointer wrap to 0
    in_valid = 3'b100;
    in_data  = {4'hF, 4'h2, 4'h1};
    #1;
    chk("r2.in_ready", 32'(in_ready), 32'b100);
    tick();
    chk_out("r2", 1'b1, 2'd2, 4'hF);
    chk("r2.orr",  32'(out_orr),  32'd1);
    chk("r2.andr", 32'(out_andr), 32'd1);
    in_valid = 3'b011;
    #1;
    chk("wrap.in_ready", 32'(in_ready), 32'b001);
    in_valid = 3'b010;
    in_data  = {4'hF, 4'h0, 4'h1};
    #1;
    chk("r1.in_ready", 32'(in_ready), 32'b010);
    tick();
    chk_out("r1", 1'b1, 2'd1, 4'h0);
    chk("r1.orr",  32'(out_orr),  32'd0);
    chk("r1.andr", 32'(out_andr), 32'd0);

    // backpressure: slot frozen, no grants
    out_ready = 1'b0;
    in_valid  = 3'b111;
    in_data   = {4'h3, 4'h2, 4'h1};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("bp%0d", i), 1'b1, 2'd1, 4'h0);
      chk($sformatf("bp%0d.in_ready", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", 32'(in_ready), 32'b100);
    tick();
    chk_out("bp.after", 1'b1, 2'd2, 4'h3);

    // asynchronous reset between edges while full
    #2;
    ASYNCRESET = 1'b1;
    #1;
    chk("arst.out_valid", 32'(out_valid), 32'd0);
    chk("arst.in_ready",  32'(in_ready),  32'd0);
    chk("arst.out_data",  32'(out_data),  32'd0);
    #1;
    ASYNCRESET = 1'b0;
    #1;
    chk("arst.rel_ready", 32'(in_ready), 32'b001);
    tick();
    chk_out("arst.first", 1'b1, 2'd0, 4'h1);

    // fairness: req1 always asking, neighbours toggling
    gap = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = pat[i];
      tick();
      chk_out($sformatf("fair%0d", i), 1'b1, exp_src[i], 4'(exp_src[i]) + 4'h1);
      if (out_src == 2'd1) gap = 0;
      else gap++;
      chk($sformatf("fair%0d.gap", i), 32'(gap < 3), 32'd1);
    end

    // idle: slot drains, nothing loaded
    in_valid = 3'b000;
    tick();
    chk("idle.out_valid", 32'(out_valid), 32'd0);
    chk("idle.out_data",  32'(out_data),  32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
